// File: rtl/fpu.sv
`default_nettype none
// ============================================================================
// Module   : fpu
// Purpose  : Single-operation floating-point adder for a custom 32-bit format
//            (sign[31], exponent[30:25] biased by 31, mantissa[24:0] with a
//            hidden leading 1). Computes op_A_in + op_B_in with truncation
//            toward zero. One operation runs per reset pulse. The result and
//            the one-hot status are held until the next reset.
// Ports    : clock      - system clock
//            reset      - asynchronous, active-low reset
//            op_A_in    - operand A
//            op_B_in    - operand B
//            data_out   - registered sum, valid from the 5th edge after reset
//            status_out - registered one-hot status
//                         [0] EXACT [1] OVERFLOW [2] UNDERFLOW [3] INEXACT
// Revision : 1.0 - initial release
// ============================================================================
module fpu (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] op_A_in,
    input  logic [31:0] op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    localparam logic [3:0]  c_ST_EXACT     = 4'b0001;
    localparam logic [3:0]  c_ST_OVERFLOW  = 4'b0010;
    localparam logic [3:0]  c_ST_UNDERFLOW = 4'b0100;
    localparam logic [3:0]  c_ST_INEXACT   = 4'b1000;
    localparam logic [4:0]  c_SHIFT_CAP    = 5'd28;
    localparam logic [5:0]  c_EXP_MAX      = 6'd63;

    typedef enum logic [2:0] {
        S_READ  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;

    // Captured operands
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;

    // Aligned operands: {significand[25:0], guard, round, sticky}
    logic                r_sign;
    logic                r_sub;
    logic [5:0]          r_exp;
    logic [28:0]         r_ext_l;
    logic [28:0]         r_ext_s;

    // Raw sum with carry-out in bit 29
    logic [29:0]         r_sum;

    // Normalized fraction without hidden bit: {mantissa[24:0], G, R, S}
    logic [27:0]         r_norm;
    logic signed [7:0]   r_nexp;
    logic                r_zero;

    // ------------------------------------------------------------------
    // Align stage: decode, order by magnitude, shift the smaller operand
    // ------------------------------------------------------------------
    logic [25:0] w_sig_a;
    logic [25:0] w_sig_b;
    logic [5:0]  w_exp_a;
    logic [5:0]  w_exp_b;
    logic        w_a_ge_b;
    logic        w_sign_l;
    logic [25:0] w_sig_l;
    logic [25:0] w_sig_s;
    logic [5:0]  w_exp_l;
    logic [5:0]  w_exp_s;
    logic [5:0]  w_exp_diff;
    logic [4:0]  w_shamt;
    logic [28:0] w_ext_s_raw;
    logic [28:0] w_lost_mask;
    logic        w_sticky;
    logic [28:0] w_ext_s_shift;

    always_comb begin
        // Denormal inputs (exp==0) have no hidden bit and behave as exp 1
        w_sig_a = {(r_op_a[30:25] != 6'd0), r_op_a[24:0]};
        w_sig_b = {(r_op_b[30:25] != 6'd0), r_op_b[24:0]};
        w_exp_a = (r_op_a[30:25] != 6'd0) ? r_op_a[30:25] : 6'd1;
        w_exp_b = (r_op_b[30:25] != 6'd0) ? r_op_b[30:25] : 6'd1;

        // Exponent first, then significand, decides the larger magnitude
        w_a_ge_b = ({w_exp_a, w_sig_a} >= {w_exp_b, w_sig_b});

        w_sign_l = w_a_ge_b ? r_op_a[31] : r_op_b[31];
        w_sig_l  = w_a_ge_b ? w_sig_a : w_sig_b;
        w_sig_s  = w_a_ge_b ? w_sig_b : w_sig_a;
        w_exp_l  = w_a_ge_b ? w_exp_a : w_exp_b;
        w_exp_s  = w_a_ge_b ? w_exp_b : w_exp_a;

        w_exp_diff = w_exp_l - w_exp_s;
        // A shift of 28 already moves the whole field into the sticky bit
        w_shamt    = (w_exp_diff > 6'd28) ? c_SHIFT_CAP : w_exp_diff[4:0];

        w_ext_s_raw   = {w_sig_s, 3'b000};
        w_lost_mask   = (29'd1 << w_shamt) - 29'd1;
        w_sticky      = |(w_ext_s_raw & w_lost_mask);
        w_ext_s_shift = (w_ext_s_raw >> w_shamt) | {28'd0, w_sticky};
    end

    // ------------------------------------------------------------------
    // Normalize stage: single-cycle leading-zero count and shift
    // ------------------------------------------------------------------
    logic [4:0]        w_lzc;
    logic              w_sum_zero;
    logic [27:0]       w_norm;
    logic signed [7:0] w_nexp;

    always_comb begin
        // Highest set bit of r_sum[28:0] wins (last assignment in the loop)
        w_lzc = 5'd0;
        for (int i = 0; i < 29; i++) begin
            if (r_sum[i]) begin
                w_lzc = 5'(28 - i);
            end
        end

        w_sum_zero = (r_sum == 30'd0);

        if (r_sum[29]) begin
            // Carry-out: drop one bit into sticky, hidden bit is r_sum[29]
            w_norm = {r_sum[28:2], r_sum[1] | r_sum[0]};
            w_nexp = $signed({2'b00, r_exp}) + 8'sd1;
        end else begin
            // Hidden bit lands in bit 28 after the shift and is not kept
            w_norm = r_sum[27:0] << w_lzc;
            w_nexp = $signed({2'b00, r_exp}) - $signed({3'b000, w_lzc});
        end
    end

    // ------------------------------------------------------------------
    // Round stage: truncate, classify, saturate or flush
    // ------------------------------------------------------------------
    logic        w_ovf;
    logic        w_udf;
    logic [31:0] w_data;
    logic [3:0]  w_status;

    always_comb begin
        w_ovf = !r_zero && (r_nexp > 8'sd63);
        w_udf = !r_zero && (r_nexp < 8'sd1);

        if (w_ovf) begin
            w_data   = {r_sign, c_EXP_MAX, {25{1'b1}}};
            w_status = c_ST_OVERFLOW;
        end else if (w_udf) begin
            w_data   = {r_sign, 31'd0};
            w_status = c_ST_UNDERFLOW;
        end else if (r_zero) begin
            // Exact cancellation always yields +0
            w_data   = 32'd0;
            w_status = c_ST_EXACT;
        end else begin
            w_data   = {r_sign, r_nexp[5:0], r_norm[27:3]};
            w_status = (|r_norm[2:0]) ? c_ST_INEXACT : c_ST_EXACT;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_READ;
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_exp      <= 6'd0;
            r_ext_l    <= 29'd0;
            r_ext_s    <= 29'd0;
            r_sum      <= 30'd0;
            r_norm     <= 28'd0;
            r_nexp     <= 8'sd0;
            r_zero     <= 1'b0;
            data_out   <= 32'd0;
            status_out <= 4'd0;
        end else begin
            case (r_state)
                S_READ: begin
                    r_op_a  <= op_A_in;
                    r_op_b  <= op_B_in;
                    r_state <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_sign  <= w_sign_l;
                    r_sub   <= r_op_a[31] ^ r_op_b[31];
                    r_exp   <= w_exp_l;
                    r_ext_l <= {w_sig_l, 3'b000};
                    r_ext_s <= w_ext_s_shift;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    // Larger magnitude is always r_ext_l, so no borrow-out
                    if (r_sub) begin
                        r_sum <= {1'b0, r_ext_l} - {1'b0, r_ext_s};
                    end else begin
                        r_sum <= {1'b0, r_ext_l} + {1'b0, r_ext_s};
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_norm  <= w_norm;
                    r_nexp  <= w_nexp;
                    r_zero  <= w_sum_zero;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    data_out   <= w_data;
                    status_out <= w_status;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_READ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu
// Purpose  : Self-checking bench for fpu. Stimulus pushes the expected
//            result into a queue; an independent monitor pops and compares
//            when the DUT raises a non-zero status, and also checks the
//            cleared state during reset, zero outputs before the result,
//            exact latency and result hold.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [3:0]  status;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tb_edges = 0;
    bit          tb_done = 1'b0;

    fpu u_dut (
        .clock      (clock),
        .reset      (reset),
        .op_A_in    (op_a),
        .op_B_in    (op_b),
        .data_out   (data_out),
        .status_out (status_out)
    );

    always #5 clock = ~clock;

    // Rising edges seen since the last reset release
    always @(posedge clock or negedge reset) begin
        if (!reset) tb_edges <= 0;
        else        tb_edges <= tb_edges + 1;
    end

    // ------------------------------------------------------------------
    // Reference model: exact integer arithmetic on wide values, then
    // truncate the true sum to a 26-bit significand.
    // ------------------------------------------------------------------
    function automatic exp_t ref_add(input logic [31:0] a, input logic [31:0] b);
        exp_t         r;
        logic [127:0] ma, mb, mag, kept;
        int           ea, eb, emin, p, e;
        logic         sr, inexact;
        r.a = a;
        r.b = b;
        ea = (a[30:25] == 6'd0) ? 1 : int'(a[30:25]);
        eb = (b[30:25] == 6'd0) ? 1 : int'(b[30:25]);
        emin = (ea < eb) ? ea : eb;
        ma = {102'd0, (a[30:25] != 6'd0), a[24:0]} << (ea - emin);
        mb = {102'd0, (b[30:25] != 6'd0), b[24:0]} << (eb - emin);
        sr = (ma >= mb) ? a[31] : b[31];
        if (a[31] == b[31])  mag = ma + mb;
        else if (ma >= mb)   mag = ma - mb;
        else                 mag = mb - ma;
        if (mag == 128'd0) begin
            r.data = 32'd0;
            r.status = 4'b0001;
            return r;
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = emin + p - 25;
        if (e > 63) begin
            r.data = {sr, 31'h7FFF_FFFF};
            r.status = 4'b0010;
        end else if (e < 1) begin
            r.data = {sr, 31'd0};
            r.status = 4'b0100;
        end else begin
            if (p >= 25) begin
                kept = mag >> (p - 25);
                inexact = ((kept << (p - 25)) != mag);
            end else begin
                kept = mag << (25 - p);
                inexact = 1'b0;
            end
            r.data = {sr, e[5:0], kept[24:0]};
            r.status = inexact ? 4'b1000 : 4'b0001;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic run_op(input exp_t e);
        @(posedge clock);
        #1;
        reset = 1'b0;          // asserted just after an edge: async clear
        op_a  = e.a;
        op_b  = e.b;
        @(negedge clock);
        #1;
        exp_q.push_back(e);
        reset = 1'b1;
        @(posedge clock);      // edge 1 captures operands
        #1;
        op_a = $urandom();
        op_b = $urandom();
        repeat (7) @(negedge clock);
    endtask

    task automatic run_dir(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.a = a; e.b = b; e.data = d; e.status = s;
        run_op(e);
    endtask

    task automatic run_rnd(input logic [31:0] a, input logic [31:0] b);
        run_op(ref_add(a, b));
    endtask

    // Start an operation and leave it after edge 2; the next run_op
    // asserts reset just after edge 3.
    task automatic abort_op(input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #1;
        reset = 1'b0;
        op_a  = a;
        op_b  = b;
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    function automatic logic [31:0] near_b(input logic [31:0] a);
        int eb;
        eb = int'(a[30:25]) + int'($urandom_range(6, 0)) - 3;
        if (eb < 0)  eb = 0;
        if (eb > 63) eb = 63;
        return {1'($urandom()), eb[5:0], 25'($urandom())};
    endfunction

    initial begin : stimulus
        logic [31:0] a, b;
        reset = 1'b1;
        op_a  = 32'd0;
        op_b  = 32'd0;
        #1 reset = 1'b0;

        run_dir(32'hBE00_0000, 32'hBE00_0000, 32'hC000_0000, 4'b0001);
        run_dir(32'h4000_0000, 32'hC200_0000, 32'hC000_0000, 4'b0001);
        run_dir(32'h3E00_0000, 32'hBE00_0000, 32'h0000_0000, 4'b0001);
        run_dir(32'h3F00_0000, 32'h3C00_0000, 32'h4000_0000, 4'b0001);
        run_dir(32'h3F00_0000, 32'h4040_0000, 32'h41C0_0000, 4'b0001);
        run_dir(32'h3E00_0000, 32'h0000_0000, 32'h3E00_0000, 4'b0001);
        run_dir(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0010);
        run_dir(32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b0100);
        run_dir(32'h3E00_0000, 32'h0000_0001, 32'h3E00_0000, 4'b1000);
        run_dir(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0010);

        abort_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_dir(32'h3F00_0000, 32'h3C00_0000, 32'h4000_0000, 4'b0001);

        for (int n = 0; n < 80; n++) begin
            a = $urandom();
            case (n % 5)
                0: b = $urandom();
                1: b = near_b(a);
                2: b = {~a[31], a[30:3], 3'($urandom())};
                3: begin
                    a = {1'($urandom()), 6'($urandom_range(2, 0)), 25'($urandom())};
                    b = {1'($urandom()), 6'($urandom_range(2, 0)), 25'($urandom())};
                end
                default: begin
                    a = {1'b0, 6'($urandom_range(63, 61)), 25'($urandom())};
                    b = {1'b0, 6'($urandom_range(63, 61)), 25'($urandom())};
                end
            endcase
            if (n % 7 == 3) abort_op($urandom(), $urandom());
            run_rnd(a, b);
        end

        repeat (2) @(negedge clock);
        tb_done = 1'b1;
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        exp_t held;
        bit   consumed;
        consumed = 1'b0;
        held = '0;
        while (!tb_done) begin
            @(negedge clock);
            if (!reset) begin
                n_cmp++;
                if (data_out !== 32'd0 || status_out !== 4'd0) begin
                    n_bad++;
                    $display("FAIL reset_clear: data_out=%h status_out=%b, required 00000000/0000",
                             data_out, status_out);
                end
                consumed = 1'b0;
            end else if (!consumed) begin
                if (status_out !== 4'd0) begin
                    consumed = 1'b1;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_output: data_out=%h status_out=%b, required no output",
                                 data_out, status_out);
                    end else begin
                        e = exp_q.pop_front();
                        held = e;
                        if (tb_edges != 5) begin
                            n_bad++;
                            $display("FAIL latency: a=%h b=%h result at edge %0d, required edge 5",
                                     e.a, e.b, tb_edges);
                        end
                        n_cmp++;
                        if (data_out !== e.data) begin
                            n_bad++;
                            $display("FAIL data: a=%h b=%h data_out=%h, required %h",
                                     e.a, e.b, data_out, e.data);
                        end
                        n_cmp++;
                        if (status_out !== e.status) begin
                            n_bad++;
                            $display("FAIL status: a=%h b=%h status_out=%b, required %b",
                                     e.a, e.b, status_out, e.status);
                        end
                    end
                end else if (tb_edges >= 5) begin
                    consumed = 1'b1;
                    n_cmp++;
                    n_bad++;
                    if (exp_q.size() != 0) begin
                        held = exp_q.pop_front();
                    end
                    $display("FAIL no_result: status_out=%b data_out=%h at edge %0d, required result by edge 5",
                             status_out, data_out, tb_edges);
                end else begin
                    n_cmp++;
                    if (data_out !== 32'd0) begin
                        n_bad++;
                        $display("FAIL early_output: data_out=%h at edge %0d, required 00000000",
                                 data_out, tb_edges);
                    end
                end
            end else begin
                n_cmp++;
                if (data_out !== held.data || status_out !== held.status) begin
                    n_bad++;
                    $display("FAIL hold: data_out=%h status_out=%b, required %h/%b",
                             data_out, status_out, held.data, held.status);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expected results never produced, required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
